// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package loader_pkg;

    localparam int CNT_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        HOLD,
        RUN,
        ERR,
        CKSUM
    } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and flags the 4th byte.
// With LOADER_CHECKSUM_EN defined it also keeps the running XOR of the stream.
module byte_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        idx_clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
`ifdef LOADER_CHECKSUM_EN
    ,
    input  logic        xor_en,
    input  logic        xor_init,
    output logic [7:0]  xor_acc
`endif
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0] byte_idx;

    assign word_valid = byte_en && (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    // byte_idx wraps back to 0 naturally after the last byte of a word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx <= '0;
            word     <= '0;
        end else begin
            if (idx_clr) begin
                byte_idx <= '0;
            end else if (byte_en) begin
                byte_idx <= byte_idx + 1'b1;
            end
            if (byte_en) begin
                word[{byte_idx, 3'b000} +: 8] <= byte_in;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // The first header byte restarts the XOR so a reload never inherits old state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_acc <= '0;
        end else if (xor_init) begin
            xor_acc <= byte_in;
        end else if (xor_en) begin
            xor_acc <= xor_acc ^ byte_in;
        end
    end
`endif

endmodule

// File: rtl/prog_loader.sv
// Boot loader: byte stream -> imem words, holding the CPU in reset until done.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RST_HOLD = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    localparam int          HOLD_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
    localparam logic [31:0] CAP    = 32'd1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CKSUM;
`else
    localparam state_t AFTER_DATA = HOLD;
`endif

    state_t            state, state_nx;
    logic [7:0]        cnt_lo;
    logic [CNT_W-1:0]  n_words, word_cnt, word_cnt_inc, n_hdr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              too_big, last_word, restart, word_valid, byte_en, hdr1_acc;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_acc;
`endif

    assign n_hdr        = {in_data, cnt_lo};
    assign too_big      = {{(32 - CNT_W){1'b0}}, n_hdr} > CAP;
    assign word_cnt_inc = word_cnt + 1'b1;
    assign last_word    = (word_cnt_inc == n_words);
    assign restart      = start && (state == RUN || state == ERR);
    assign byte_en      = (state == DATA) && in_valid;
    assign hdr1_acc     = (state == HDR1) && in_valid;
    assign imem_we      = (state == WRITE);
    assign load_done    = (state == RUN);

    byte_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .idx_clr    (hdr1_acc),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word       (imem_wdata),
        .word_valid (word_valid)
`ifdef LOADER_CHECKSUM_EN
        ,
        .xor_en     (in_valid && in_ready && state != CKSUM),
        .xor_init   ((state == HDR0) && in_valid),
        .xor_acc    (xor_acc)
`endif
    );

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            HDR0: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_hdr == '0)  state_nx = AFTER_DATA;
                    else if (too_big) state_nx = ERR;
                    else              state_nx = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (word_valid) state_nx = WRITE;
            end
            WRITE: state_nx = last_word ? AFTER_DATA : DATA;
            HOLD:  if (hold_cnt <= HOLD_W'(1)) state_nx = RUN;
            RUN:   if (start) state_nx = HDR0;
            ERR:   if (start) state_nx = HDR0;
`ifdef LOADER_CHECKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = (in_data == xor_acc) ? HOLD : ERR;
            end
`endif
            default: state_nx = HDR0;
        endcase
    end

    // cpu_rst is registered: it drops one cycle after entering RUN and rises on the start edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HDR0;
            cnt_lo    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            imem_addr <= '0;
            hold_cnt  <= '0;
            cpu_rst   <= 1'b1;
            load_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            cpu_rst <= !(state == RUN && !start);
            if ((state == HDR0) && in_valid) cnt_lo <= in_data;
            if (hdr1_acc) begin
                n_words  <= n_hdr;
                word_cnt <= '0;
            end
            if (state == WRITE) begin
                imem_addr <= imem_addr + 1'b1;
                word_cnt  <= word_cnt_inc;
            end
            if (state_nx == HOLD && state != HOLD) begin
                hold_cnt <= HOLD_W'(RST_HOLD);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (restart) begin
                imem_addr <= '0;
                load_err  <= 1'b0;
            end
            if (state_nx == ERR && state != ERR) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (default and LOADER_CHECKSUM_EN builds).
module tb_prog_loader;

    localparam int ADDR_W   = 8;
    localparam int RST_HOLD = 2;
`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [7:0]        in_data;
    logic              in_ready, imem_we, cpu_rst, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] wds [0:3];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, we_cnt = 0, we_cyc = 0, acc_cyc = 0, fall_cyc = 0;
    logic rst_q = 1'b1;
    int w0;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // imem model and event timestamps (cyc == number of rising edges seen)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            we_cnt         <= we_cnt + 1;
            we_cyc         <= cyc + 1;
        end
        if (in_valid && in_ready) acc_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        rst_q <= cpu_rst;
        if (rst_q && !cpu_rst) fall_cyc <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            for (int k = 0; k < 6 && $urandom_range(1, 0) == 1; k++) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rdy_tmo", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input int n, input int nw, input bit gaps, input bit ck_bad, input bit with_ck);
        logic [15:0] nn;
        logic [31:0] w;
        logic [7:0]  x;
        nn = 16'(n);
        x  = nn[7:0] ^ nn[15:8];
        send_byte(nn[7:0], gaps);
        send_byte(nn[15:8], gaps);
        for (int i = 0; i < nw; i++) begin
            w = wds[i];
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8], gaps);
                x = x ^ w[8*j +: 8];
            end
        end
        if (CK == 1 && with_ck) send_byte(ck_bad ? (x ^ 8'h01) : x, gaps);
    endtask

    task automatic wait_run();
        int g = 0;
        while (!load_done && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("run_tmo", load_done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_we",    imem_we, 0);
        check("rst_addr",  imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpu",   cpu_rst, 1);
        check("rst_done",  load_done, 0);
        check("rst_err",   load_err, 0);
        rst = 1'b1;
        @(negedge clk);

        // two-word image, in_valid always high
        wds[0] = 32'h2000_0013; wds[1] = 32'h2401_0005;
        w0 = we_cnt;
        load(2, 2, 1'b0, 1'b0, 1'b1);
        wait_run();
        check("w2_mem0",  mem[0], 32'h2000_0013);
        check("w2_mem1",  mem[1], 32'h2401_0005);
        check("w2_wecnt", we_cnt - w0, 2);
        check("w2_fall",  fall_cyc - we_cyc, 3 + CK);
        check("w2_done",  load_done, 1);
        check("w2_cpu",   cpu_rst, 0);
        check("w2_ready", in_ready, 0);
        check("w2_addr",  imem_addr, 2);

        pulse_start();
        check("st_cpu",   cpu_rst, 1);
        check("st_done",  load_done, 0);
        check("st_addr",  imem_addr, 0);
        check("st_ready", in_ready, 1);

        // empty image
        w0 = we_cnt;
        load(0, 0, 1'b0, 1'b0, 1'b1);
        wait_run();
        check("n0_wecnt", we_cnt - w0, 0);
        check("n0_fall",  fall_cyc - acc_cyc, RST_HOLD + 1);
        check("n0_done",  load_done, 1);

        // oversize count 513
        pulse_start();
        load(513, 0, 1'b0, 1'b0, 1'b0);
        check("big_err",   load_err, 1);
        check("big_cpu",   cpu_rst, 1);
        check("big_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("big_stick", load_err, 1);
        pulse_start();
        check("clr_err",   load_err, 0);
        check("clr_ready", in_ready, 1);

        // four words with random valid gaps
        wds[0] = 32'h2000_0013; wds[1] = 32'h2401_0005;
        wds[2] = 32'hDEAD_BEEF; wds[3] = 32'h00C0_FFEE;
        w0 = we_cnt;
        load(4, 4, 1'b1, 1'b0, 1'b1);
        wait_run();
        for (int i = 0; i < 4; i++) check($sformatf("gap_mem%0d", i), mem[i], wds[i]);
        check("gap_wecnt", we_cnt - w0, 4);
        check("gap_done",  load_done, 1);

        // abort with rst after first word, then reload
        pulse_start();
        wds[0] = 32'hA1B2_C3D4;
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int j = 0; j < 4; j++) send_byte(wds[0][8*j +: 8], 1'b0);
        @(negedge clk);
        check("ab_mem0", mem[0], 32'hA1B2_C3D4);
        check("ab_addr_pre", imem_addr, 1);
        rst = 1'b0;
        #1;
        check("ab_addr",  imem_addr, 0);
        check("ab_wdata", imem_wdata, 0);
        check("ab_cpu",   cpu_rst, 1);
        check("ab_ready", in_ready, 1);
        check("ab_we",    imem_we, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        wds[0] = 32'h1122_3344; wds[1] = 32'h5566_7788;
        load(2, 2, 1'b0, 1'b0, 1'b1);
        wait_run();
        check("re_mem0", mem[0], 32'h1122_3344);
        check("re_mem1", mem[1], 32'h5566_7788);
        check("re_done", load_done, 1);

`ifdef LOADER_CHECKSUM_EN
        // corrupted checksum byte
        pulse_start();
        wds[0] = 32'h2000_0013; wds[1] = 32'h2401_0005;
        load(2, 2, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("ck_err",  load_err, 1);
        check("ck_cpu",  cpu_rst, 1);
        check("ck_done", load_done, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the instruction memory that `cpu` fetches from.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit little-endian words.
- Writes the words into imem at consecutive word addresses.
- Holds the CPU in reset until the program image is complete, then releases it.
- Sits between the host/UART byte source and the top-level `cpu` + imem instance.

Parameters:
- ADDR_W, 8, imem word-address width; capacity = 2**ADDR_W words.
- RST_HOLD, 2, cycles cpu_rst stays high after the last imem write.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a reload. Honoured only in RUN or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted when in_valid && in_ready at a clk edge.
- imem_we  output  1  one-cycle imem write strobe.
- imem_addr  output  ADDR_W  imem word address.
- imem_wdata  output  32  imem write data.
- cpu_rst  output  1  active-high reset driven to `cpu`.
- load_done  output  1  high while in RUN.
- load_err  output  1  sticky error flag; cleared only by rst low or by start.

Behaviour:
- Stream format: count lo byte, count hi byte (N, 16-bit), then N words of 4 bytes each, LSB first.
- States: HDR0, HDR1, DATA, WRITE, HOLD, RUN, ERR.
- On rst low (asynchronous), all outputs take their reset values:
  - state = HDR0, imem_we = 0, imem_addr = 0, imem_wdata = 0
  - cpu_rst = 1, load_done = 0, load_err = 0, internal counters = 0.
- in_ready is combinational and equals 1 only in HDR0, HDR1 and DATA.
- HDR0: on accept, latch N[7:0] and go to HDR1.
- HDR1: on accept, latch N[15:8], then:
  - N == 0 -> HOLD.
  - N > 2**ADDR_W -> ERR; load_err = 1.
  - Otherwise -> DATA with byte_idx = 0 and word_cnt = 0.
- DATA:
  - Each accepted byte shifts into imem_wdata[8*byte_idx +: 8].
  - The 4th byte goes to WRITE.
  - A cycle with in_valid low holds state; there is no timeout.
- WRITE (exactly one cycle):
  - imem_we = 1 with the current addr and wdata; in_ready = 0.
  - Next cycle: imem_addr += 1 and word_cnt += 1.
  - If word_cnt + 1 == N go to HOLD, otherwise go to DATA.
- imem_addr wraps at 2**ADDR_W. Wrap is unreachable after the N check, except when N == 2**ADDR_W, where addr ends at 0 (harmless).
- HOLD: cpu_rst stays 1 for RST_HOLD cycles, counted by a down-counter, then go to RUN.
- RUN:
  - cpu_rst = 0 (registered), load_done = 1, in_ready = 0.
  - start -> HDR0: cpu_rst = 1 next cycle, load_done = 0, addr = 0.
- ERR: cpu_rst = 1, in_ready = 0. start -> HDR0 and clears load_err.
- start while in HDR0–HOLD is ignored.
- Bytes offered while in_ready = 0 are not consumed; the source must hold them.
- rst low mid-load aborts the load. Already-written imem words are not cleared. The load restarts at HDR0.
- Latency per word:
  - 4 accept cycles + 1 WRITE cycle, so the minimum is 5 clk per word.
  - Last write to cpu_rst falling edge = RST_HOLD + 1 cycles.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last data byte, a CKSUM state accepts one byte: the XOR of all header and data bytes.
  - Match -> HOLD.
  - Mismatch -> ERR with load_err = 1.
  - For N == 0 the checksum byte is still required; it is the XOR of the two count bytes.
- Without the macro: no CKSUM state, and the stream ends after the last data byte.

Decomposition:
- Shared package `loader_pkg` contains:
  - the state enum constants (HDR0..ERR, CKSUM);
  - the byte-count width constant (16);
  - the bytes-per-word constant (4).
- One natural sub-module, `byte_word_packer`:
  - assembles 4 bytes into a word;
  - has a byte_idx counter;
  - outputs a word_valid pulse;
  - holds the running XOR when LOADER_CHECKSUM_EN is defined.
- The FSM and address/count logic stay in prog_loader.

Test Plan:
- Reset then stream 02 00 | 13 00 00 20 | 05 00 01 24, in_valid always high:
  - imem[0] = 0x20000013 and imem[1] = 0x24010005;
  - imem_we high exactly 2 cycles;
  - cpu_rst falls 3 cycles after the 2nd write; load_done = 1.
- Stream 00 00:
  - no imem_we;
  - cpu_rst falls RST_HOLD + 1 cycles after the HDR1 accept.
- Stream 01 02 (N = 513 > 256):
  - load_err = 1, cpu_rst stays 1, in_ready = 0;
  - a start pulse clears load_err and returns to HDR0.
- Random in_valid gaps (about 50%) during a 4-word load:
  - written words identical to the gap-free run;
  - no byte lost or duplicated.
- Mid-load (after word 1), drive rst low for 1 cycle:
  - outputs return to reset values immediately;
  - a fresh full stream loads correctly from addr 0.
- LOADER_CHECKSUM_EN defined:
  - correct checksum byte -> RUN;
  - a corrupted checksum byte (flip bit 0) -> ERR, load_err = 1, cpu_rst stays 1.
